sprite_blitter: RTL

//  Sits between MovementDatapath and vga_adapter. It turns one sprite draw/erase request
//  (top-left x,y + sprite id) into a raster stream of single-pixel writes.

---
 rtl/sprite_blitter_pkg.sv | 27 ++
 rtl/sprite_blitter_rom.sv | 37 +++
 rtl/sprite_blitter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sprite_blitter_pkg.sv
// Shared definitions for the sprite blitter slice.
// Holds the default sprite and screen geometry, the sprite ids, the palette
// colours used by the sprite ROM, the FSM state encoding, and the ROM pixel
// record type.
package sprite_blitter_pkg;

  localparam int SPR_W = 8;
  localparam int SPR_H = 8;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  localparam logic SPR_CROSS = 1'b0;
  localparam logic SPR_BIRD  = 1'b1;

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] WHITE  = 3'b111;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b110;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  typedef struct packed {
    logic       opaque;
    logic [2:0] colour;
  } pixel_t;

endpackage

// File: rtl/sprite_blitter_rom.sv
// Combinational sprite bitmap lookup shared by the player and bird paths.
// Ports:
//   sprite  in  1      sprite id (SPR_CROSS / SPR_BIRD)
//   row     in  ROW_W  pixel row inside the sprite
//   col     in  COL_W  pixel column inside the sprite
//   pix     out 4      {opaque, colour[2:0]}; colour is BLACK where transparent
module sprite_blitter_rom #(
  parameter int ROW_W = 3,
  parameter int COL_W = 3
) (
  input  logic                      sprite,
  input  logic [ROW_W-1:0]          row,
  input  logic [COL_W-1:0]          col,
  output sprite_blitter_pkg::pixel_t pix
);
  import sprite_blitter_pkg::*;

  int r;
  int c;

  always_comb begin
    r   = int'(row);
    c   = int'(col);
    pix = '{opaque: 1'b0, colour: BLACK};
    if (sprite == SPR_CROSS) begin
      // Plus sign: full row 3 and full column 3.
      if (r == 3 || c == 3) pix = '{opaque: 1'b1, colour: WHITE};
    end else begin
      // Beak sits just right of the body on the eye row.
      if (r == 3 && c == 7)
        pix = '{opaque: 1'b1, colour: YELLOW};
      else if (r >= 2 && r <= 5 && c >= 1 && c <= 6)
        pix = '{opaque: 1'b1, colour: RED};
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: turns one draw/erase request into a raster stream of
// single-pixel writes for the 160x120 vga_adapter, clipping at the screen
// edge and skipping transparent pixels.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (ready only while idle)
//   req_x/req_y            sprite top-left corner
//   req_sprite/req_erase   sprite id, erase-to-background flag
//   vga_x/vga_y            registered pixel coordinates
//   vga_colour/vga_plot    registered pixel colour and write strobe
//   done                   one-cycle pulse after the last pixel
// Timing: the cycle in which the handshake is sampled is cycle 0. Pixel 0 is
// looked up from the live req_* inputs in that cycle so it is on the vga_*
// registers in cycle 1; pixel n follows in cycle n+1, done in the cycle after
// the last pixel, and req_ready one cycle later.
module sprite_blitter #(
  parameter int         SPR_W     = sprite_blitter_pkg::SPR_W,
  parameter int         SPR_H     = sprite_blitter_pkg::SPR_H,
  parameter int         SCR_W     = sprite_blitter_pkg::SCR_W,
  parameter int         SCR_H     = sprite_blitter_pkg::SCR_H,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  input  logic       req_sprite,
  input  logic       req_erase,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       done
);
  import sprite_blitter_pkg::*;

  localparam int CX_W = $clog2(SPR_W);
  localparam int CY_W = $clog2(SPR_H);

  state_t          state, state_nx;
  logic [CX_W-1:0] cx;
  logic [CY_W-1:0] cy;
  logic [7:0]      lat_x;
  logic [6:0]      lat_y;
  logic            lat_sprite;
  logic            lat_erase;

  logic            hs;
  logic            cnt_zero;
  logic            vld_p0;
  logic [7:0]      src_x_p0;
  logic [6:0]      src_y_p0;
  logic            src_sprite_p0;
  logic            src_erase_p0;
  logic [8:0]      sum_x_p0;
  logic [7:0]      sum_y_p0;
  pixel_t          pix_p0;

  // Sums are one bit wider than the coordinates so a sprite hanging off the
  // right/bottom edge is clipped instead of wrapping to the other side.
  function automatic logic on_screen(input logic [8:0] sx, input logic [7:0] sy);
    return (sx < 9'(SCR_W)) && (sy < 8'(SCR_H));
  endfunction

  assign hs        = req_valid & req_ready;
  assign req_ready = (state == IDLE);
  assign done      = (state == DONE);

  // Counters come back to zero after the last pixel, which marks the final
  // DRAW cycle (no pixel issued, move on to DONE).
  assign cnt_zero = (cx == '0) && (cy == '0);

  // Stage p0: pixel lookup and clip. Pixel 0 comes from the live request.
  assign vld_p0        = hs | ((state == DRAW) & ~cnt_zero);
  assign src_x_p0      = hs ? req_x      : lat_x;
  assign src_y_p0      = hs ? req_y      : lat_y;
  assign src_sprite_p0 = hs ? req_sprite : lat_sprite;
  assign src_erase_p0  = hs ? req_erase  : lat_erase;
  assign sum_x_p0      = {1'b0, src_x_p0} + 9'(cx);
  assign sum_y_p0      = {1'b0, src_y_p0} + 8'(cy);

  sprite_blitter_rom #(
    .ROW_W(CY_W),
    .COL_W(CX_W)
  ) u_rom (
    .sprite(src_sprite_p0),
    .row   (cy),
    .col   (cx),
    .pix   (pix_p0)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (hs) state_nx = DRAW;
      DRAW:    if (cnt_zero) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cx         <= '0;
      cy         <= '0;
      lat_x      <= '0;
      lat_y      <= '0;
      lat_sprite <= 1'b0;
      lat_erase  <= 1'b0;
    end else begin
      state <= state_nx;
      if (hs) begin
        lat_x      <= req_x;
        lat_y      <= req_y;
        lat_sprite <= req_sprite;
        lat_erase  <= req_erase;
      end
      if (vld_p0) begin
        if (cx == CX_W'(SPR_W - 1)) begin
          cx <= '0;
          cy <= cy + CY_W'(1);
        end else begin
          cx <= cx + CX_W'(1);
        end
      end
    end
  end

  // Stage p1: registered vga outputs; coordinates/colour hold when idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= vld_p0 & pix_p0.opaque & on_screen(sum_x_p0, sum_y_p0);
      if (vld_p0) begin
        vga_x      <= sum_x_p0[7:0];
        vga_y      <= sum_y_p0[6:0];
        vga_colour <= src_erase_p0 ? BG_COLOUR : pix_p0.colour;
      end
    end
  end

endmodule
